// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous-read BRAM.
// Each access takes IDLE -> ISSUE -> RESP; out-of-range addresses are trapped, never aliased.
module mem_bus_arbiter #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
    localparam int         W         = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,

    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,

    output logic          s_en,
    output logic [3:0]    s_we,
    output logic [W-1:0]  s_addr,
    output logic [31:0]   s_wdata,
    input  logic [31:0]   s_rdata,

    output logic [1:0]    grant,
    output logic          err,
    output logic [31:0]   err_addr
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        in_range_q, in_range_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        pick_m1;
    logic [31:0] req_addr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        issue_active;
    logic [31:0] resp_data;

    // last_grant_q set means m1 was served last, so m0 wins the next tie
    always_comb begin
        pick_m1  = m1_valid && (!m0_valid || !last_grant_q);
        req_addr = pick_m1 ? m1_addr : m0_addr;
    end

    always_comb begin
        sel_addr  = grant_q[1] ? m1_addr  : m0_addr;
        sel_wdata = grant_q[1] ? m1_wdata : m0_wdata;
        sel_wstrb = grant_q[1] ? m1_wstrb : m0_wstrb;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_range_d   = in_range_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        err_d        = err_q;
        err_addr_d   = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_d    = pick_m1 ? 2'b10 : 2'b01;
                    in_range_d = (req_addr[31:2] < WORD_LIMIT);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!in_range_q && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = sel_addr;
                end
                m0_ready_d = grant_q[0];
                m1_ready_d = grant_q[1];
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                last_grant_d = grant_q[1];
                grant_d      = 2'b00;
                state_d      = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            in_range_q   <= 1'b0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            in_range_q   <= in_range_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Gating with reset keeps an aborted ISSUE cycle from clocking a write into the BRAM
    always_comb begin
        issue_active = (state_q == ST_ISSUE) && !reset;
        s_en         = issue_active && in_range_q;
        s_we         = (issue_active && in_range_q) ? sel_wstrb : 4'b0000;
        s_addr       = sel_addr[W+1:2];
        s_wdata      = sel_wdata;
    end

    // BRAM data only arrives in the RESP cycle, so read data is steered rather than registered
    always_comb begin
        if (sel_wstrb != 4'b0000) begin
            resp_data = 32'd0;
        end else if (in_range_q) begin
            resp_data = s_rdata;
        end else begin
            resp_data = ERR_RDATA;
        end
        m0_rdata = m0_ready_q ? resp_data : 32'd0;
        m1_rdata = m1_ready_q ? resp_data : 32'd0;
    end

    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign grant    = grant_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural BRAM and a per-master
// scoreboard of expected read data popped whenever a ready pulse appears.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_en;
    logic [3:0]  s_we;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err;
    logic [31:0] err_addr;

    logic [31:0] mem [256];
    logic [31:0] refMem [256];
    logic [31:0] memWord;
    logic        initDone = 1'b0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    mem_bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (m0_valid),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (m1_valid),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_en     (s_en),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .err      (err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port BRAM with one-cycle synchronous read
    always @(posedge clk) begin
        if (!initDone) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[4]   <= 32'h1234_5678;
            initDone <= 1'b1;
        end else if (s_en) begin
            s_rdata <= mem[s_addr];
            memWord = mem[s_addr];
            for (int b = 0; b < 4; b++)
                if (s_we[b]) memWord[b*8 +: 8] = s_wdata[b*8 +: 8];
            mem[s_addr] <= memWord;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ready pulse must match the oldest expectation of that master
    always @(negedge clk) begin
        if (m0_ready) begin
            if (q0.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL m0_unexpected_ready observed=1 expected=0");
            end else begin
                checkOutput("m0_rdata", m0_rdata, q0.pop_front());
            end
            checkOutput("m1_idle_rdata", m1_rdata, 32'd0);
        end
        if (m1_ready) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL m1_unexpected_ready observed=1 expected=0");
            end else begin
                checkOutput("m1_rdata", m1_rdata, q1.pop_front());
            end
            checkOutput("m0_idle_rdata", m0_rdata, 32'd0);
        end
    end

    // Issue one native-bus access from master m, queue its expected result and wait for ready
    task automatic applyStimulus(input int m, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, output int lat);
        logic [31:0] expv;
        logic        rdy;
        int          idx;
        int          start;
        if (a[31:2] < 30'd256) begin
            idx = int'(a[9:2]);
            if (ws == 4'b0000) begin
                expv = refMem[idx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) refMem[idx][b*8 +: 8] = wd[b*8 +: 8];
                expv = 32'd0;
            end
        end else begin
            expv = (ws == 4'b0000) ? 32'hDEAD_BEEF : 32'd0;
        end
        if (m == 0) q0.push_back(expv); else q1.push_back(expv);
        @(negedge clk);
        if (m == 0) begin
            m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
        end else begin
            m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
        end
        start = cyc;
        lat   = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rdy = (m == 0) ? m0_ready : m1_ready;
            if (rdy) begin
                lat = cyc - start;
                break;
            end
        end
        if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        if (lat < 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL m%0d_timeout observed=no_ready expected=ready_within_12", m);
        end
    endtask

    int lat0, lat1, maxLat0, maxLat1, l0, l1;

    initial begin
        reset = 1'b1;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        for (int i = 0; i < 256; i++) refMem[i] = 32'(i) * 32'h0101_0101;
        refMem[4] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_m0_ready", 32'(m0_ready), 32'd0);
        checkOutput("rst_m1_ready", 32'(m1_ready), 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
        checkOutput("rst_s_en", 32'(s_en), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;

        $display("[TB] basic read and ISSUE-cycle bus");
        fork
            applyStimulus(0, 32'h10, 32'd0, 4'b0000, lat0);
            begin
                @(negedge clk); @(negedge clk);
                checkOutput("rd_s_en", 32'(s_en), 32'd1);
                checkOutput("rd_s_we", 32'(s_we), 32'd0);
                checkOutput("rd_s_addr", 32'(s_addr), 32'd4);
                checkOutput("rd_grant", 32'(grant), 32'd1);
            end
        join
        checkOutput("rd_latency", 32'(lat0), 32'd2);

        $display("[TB] byte-masked write then readback");
        fork
            applyStimulus(0, 32'h20, 32'hAABB_CCDD, 4'b0101, lat0);
            begin
                @(negedge clk); @(negedge clk);
                checkOutput("wr_s_we", 32'(s_we), 32'b0101);
                checkOutput("wr_s_addr", 32'(s_addr), 32'd8);
                checkOutput("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
            end
        join
        applyStimulus(0, 32'h20, 32'd0, 4'b0000, lat0);

        $display("[TB] tie after m0 was served goes to m1");
        fork
            applyStimulus(0, 32'h40, 32'd0, 4'b0000, lat0);
            applyStimulus(1, 32'h44, 32'd0, 4'b0000, lat1);
        join
        checkOutput("tie_m1_first_lat", 32'(lat1), 32'd2);
        checkOutput("tie_m0_second_lat", 32'(lat0), 32'd5);

        $display("[TB] tie from reset, repeated");
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            fork
                applyStimulus(0, 32'(32'h50 + r*8), 32'd0, 4'b0000, lat0);
                applyStimulus(1, 32'(32'h54 + r*8), 32'd0, 4'b0000, lat1);
            join
            checkOutput("rst_tie_m0_lat", 32'(lat0), 32'd2);
            checkOutput("rst_tie_m1_lat", 32'(lat1), 32'd5);
        end

        $display("[TB] sustained contention");
        maxLat0 = 0; maxLat1 = 0;
        fork
            for (int i = 0; i < 5; i++) begin
                applyStimulus(0, 32'(32'h100 + i*4), 32'd0, 4'b0000, l0);
                if (l0 > maxLat0) maxLat0 = l0;
            end
            for (int j = 0; j < 5; j++) begin
                applyStimulus(1, 32'(32'h200 + j*4), 32'd0, 4'b0000, l1);
                if (l1 > maxLat1) maxLat1 = l1;
            end
        join
        checkOutput("starve_m0_le6", 32'(maxLat0 <= 6 && maxLat0 >= 2), 32'd1);
        checkOutput("starve_m1_le6", 32'(maxLat1 <= 6 && maxLat1 >= 2), 32'd1);

        $display("[TB] out-of-range trapping");
        fork
            applyStimulus(0, 32'h400, 32'd0, 4'b0000, lat0);
            begin
                @(negedge clk); @(negedge clk);
                checkOutput("oor_s_en", 32'(s_en), 32'd0);
            end
        join
        checkOutput("oor_err", 32'(err), 32'd1);
        checkOutput("oor_err_addr", err_addr, 32'h400);
        fork
            applyStimulus(1, 32'h800, 32'h1111_2222, 4'b1111, lat1);
            begin
                @(negedge clk); @(negedge clk);
                checkOutput("oor_wr_s_we", 32'(s_we), 32'd0);
                checkOutput("oor_wr_s_en", 32'(s_en), 32'd0);
            end
        join
        checkOutput("oor_err_addr_sticky", err_addr, 32'h400);
        fork
            applyStimulus(0, 32'h3FC, 32'd0, 4'b0000, lat0);
            begin
                @(negedge clk); @(negedge clk);
                checkOutput("last_word_s_en", 32'(s_en), 32'd1);
                checkOutput("last_word_s_addr", 32'(s_addr), 32'd255);
            end
        join

        $display("[TB] reset during ISSUE of a write");
        @(negedge clk);
        m0_addr = 32'h30; m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'b1111; m0_valid = 1'b1;
        @(negedge clk);
        checkOutput("abort_issue_s_en", 32'(s_en), 32'd1);
        reset = 1'b1; m0_valid = 1'b0;
        #1;
        checkOutput("abort_gated_s_we", 32'(s_we), 32'd0);
        @(negedge clk);
        checkOutput("abort_ready", 32'(m0_ready), 32'd0);
        checkOutput("abort_grant", 32'(grant), 32'd0);
        checkOutput("abort_err_cleared", 32'(err), 32'd0);
        reset = 1'b0; m0_wstrb = 4'b0000;
        @(negedge clk);
        checkOutput("abort_idle_ready", 32'(m0_ready), 32'd0);
        applyStimulus(0, 32'h30, 32'd0, 4'b0000, lat0);

        repeat (2) @(negedge clk);
        checkOutput("q0_drained", 32'(q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
